// File: rtl/idli_pkg.sv
// Shared types and constants for the idli SQI link.
package idli_pkg;

    typedef logic [3:0] sqi_data_t;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        RDATA,
        WDATA,
        IGNORE
    } sqi_mem_state_t;

    localparam logic [7:0] SQI_CMD_READ     = 8'h03;
    localparam logic [7:0] SQI_CMD_WRITE    = 8'h02;
    localparam int         SQI_ADDR_NIBBLES = 6;

endpackage

// File: rtl/idli_sqi_ram_m.sv
// Byte array backing the SQI responder: one synchronous write port and
// a combinational read port sharing one address.
module idli_sqi_ram_m #(
    parameter  int DEPTH_BYTES = 65536,
    localparam int AW          = $clog2(DEPTH_BYTES)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH_BYTES];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/idli_sqi_mem_m.sv
// SQI serial-SRAM responder: decodes quad READ/WRITE from the core, with SCK
// oversampled on the system clock, and serves them from an internal array.
module idli_sqi_mem_m import idli_pkg::*; #(
    parameter int         DEPTH_BYTES   = 65536,
    parameter logic [7:0] CMD_READ      = SQI_CMD_READ,
    parameter logic [7:0] CMD_WRITE     = SQI_CMD_WRITE,
    parameter int         DUMMY_NIBBLES = 2
) (
    input  logic      i_mem_gck,
    input  logic      i_mem_rst,
    input  logic      i_mem_sck,
    input  logic      i_mem_cs,
    input  sqi_data_t i_mem_sio,
    output sqi_data_t o_mem_sio,
    output logic      o_mem_sio_oe
);

    localparam int AW   = $clog2(DEPTH_BYTES);
    // Shifter only as wide as the bits that matter: opcode or useful address.
    localparam int SH_W = (AW > 8) ? AW : 8;

    sqi_mem_state_t  state, state_nxt;
    logic            sck_q, cs_q, rise, fall;
    logic            last_cmd, last_addr, last_dummy;
    logic [7:0]      cnt;
    logic            phase, is_rd;
    logic [SH_W-5:0] sh;
    logic [SH_W-1:0] sh_nxt;
    sqi_data_t       wr_hi;
    logic [AW-1:0]   addr;
    logic            we;
    logic [7:0]      wdata, rdata;

    assign rise       = i_mem_sck & ~sck_q & ~i_mem_cs;
    assign fall       = ~i_mem_sck & sck_q & ~i_mem_cs;
    assign sh_nxt     = {sh, i_mem_sio};
    assign last_cmd   = (cnt == 8'd1);
    assign last_addr  = (cnt == 8'(SQI_ADDR_NIBBLES - 1));
    assign last_dummy = (cnt == 8'(DUMMY_NIBBLES - 1));

    always_ff @(posedge i_mem_gck) begin
        if (i_mem_rst) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (i_mem_cs) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                // Only a fresh CS assertion starts a transaction.
                IDLE:  if (cs_q) state_nxt = CMD;
                CMD:   if (rise && last_cmd)
                           state_nxt = (sh_nxt[7:0] == CMD_READ || sh_nxt[7:0] == CMD_WRITE)
                                       ? ADDR : IGNORE;
                ADDR:  if (rise && last_addr)
                           state_nxt = !is_rd ? WDATA : (DUMMY_NIBBLES == 0) ? RDATA : DUMMY;
                DUMMY: if (rise && last_dummy) state_nxt = RDATA;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        we    = (state == WDATA) && rise && phase;
        wdata = {wr_hi, i_mem_sio};
    end

    always_ff @(posedge i_mem_gck) begin
        if (i_mem_rst) begin
            sck_q        <= 1'b0;
            cs_q         <= 1'b0;
            cnt          <= '0;
            phase        <= 1'b0;
            is_rd        <= 1'b0;
            sh           <= '0;
            wr_hi        <= '0;
            addr         <= '0;
            o_mem_sio    <= '0;
            o_mem_sio_oe <= 1'b0;
        end else begin
            sck_q <= i_mem_sck;
            cs_q  <= i_mem_cs;
            if (i_mem_cs || state_nxt != state) cnt <= '0;
            else if (rise)                      cnt <= cnt + 8'd1;
            if (i_mem_cs) begin
                phase        <= 1'b0;
                o_mem_sio_oe <= 1'b0;
            end
            if (rise) sh <= sh_nxt[SH_W-5:0];
            if (state == CMD && rise && last_cmd) is_rd <= (sh_nxt[7:0] == CMD_READ);
            if (state == ADDR && rise && last_addr) addr <= sh_nxt[AW-1:0];
            if (state == WDATA && rise) begin
                phase <= ~phase;
                if (!phase) wr_hi <= i_mem_sio;
                else        addr  <= addr + 1'b1;
            end
            if (state == RDATA && fall) begin
                phase        <= ~phase;
                o_mem_sio_oe <= 1'b1;
                o_mem_sio    <= phase ? rdata[3:0] : rdata[7:4];
                if (phase) addr <= addr + 1'b1;
            end
        end
    end

    idli_sqi_ram_m #(.DEPTH_BYTES(DEPTH_BYTES)) u_ram (
        .clk   (i_mem_gck),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Directed bench for idli_sqi_mem_m: SQI write/read, wrap, bad opcode, abort and reset.
module tb_idli_sqi_mem_m;
    import idli_pkg::*;

    logic      gck = 1'b0;
    logic      rst = 1'b1;
    logic      sck = 1'b0;
    logic      cs  = 1'b0;
    sqi_data_t sio_in = '0;
    sqi_data_t sio_out;
    logic      oe;
    int        checks   = 0;
    int        failures = 0;

    idli_sqi_mem_m dut (
        .i_mem_gck    (gck),
        .i_mem_rst    (rst),
        .i_mem_sck    (sck),
        .i_mem_cs     (cs),
        .i_mem_sio    (sio_in),
        .o_mem_sio    (sio_out),
        .o_mem_sio_oe (oe)
    );

    always #5 gck = ~gck;

    task automatic tick(input int n);
        repeat (n) @(posedge gck);
        #1;
    endtask

    // One SCK period with a nibble presented for the rising edge.
    task automatic nib(input logic [3:0] n);
        sck = 1'b0; sio_in = n; tick(2);
        sck = 1'b1; tick(2);
    endtask

    // One SCK period, sampling what the responder drove after the fall.
    task automatic rd(output logic [3:0] n, output logic o);
        sck = 1'b0; tick(2);
        n = sio_out; o = oe;
        sck = 1'b1; tick(2);
    endtask

    task automatic cs_lo();
        cs = 1'b0; tick(2);
    endtask

    task automatic cs_hi();
        sck = 1'b0; cs = 1'b1; tick(3);
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
        cs_lo();
        nib(op[7:4]); nib(op[3:0]);
        for (int i = 5; i >= 0; i--) nib(a[i*4 +: 4]);
    endtask

    task automatic start_read(input logic [23:0] a);
        send_hdr(8'h03, a);
        nib(4'h0); nib(4'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1; cs = 1'b0;
        nib(4'h0); nib(4'h2); nib(4'h0);
        checks++; if (sio_out !== 4'h0) begin failures++; $display("FAIL reset_sio: got %h want 0", sio_out); end
        checks++; if (oe !== 1'b0) begin failures++; $display("FAIL reset_oe: got %b want 0", oe); end
        rst = 1'b0;
        nib(4'h0); nib(4'h2); nib(4'h0); nib(4'h0); nib(4'h0); nib(4'h0); nib(4'h1); nib(4'h0);
        checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL reset_idle_cs_low: got %0d want %0d", dut.state, IDLE); end
        checks++; if (oe !== 1'b0) begin failures++; $display("FAIL reset_oe_after: got %b want 0", oe); end
        cs_hi();
    endtask

    task automatic test_write_read();
        logic [3:0] exp [4] = '{4'hA, 4'h5, 4'h3, 4'hC};
        logic [3:0] n;
        logic       o;
        send_hdr(8'h02, 24'h000010);
        for (int i = 0; i < 4; i++) nib(exp[i]);
        cs_hi();
        checks++; if (dut.u_ram.mem[16'h0010] !== 8'hA5) begin failures++; $display("FAIL wr_mem10: got %h want a5", dut.u_ram.mem[16'h0010]); end
        checks++; if (dut.u_ram.mem[16'h0011] !== 8'h3C) begin failures++; $display("FAIL wr_mem11: got %h want 3c", dut.u_ram.mem[16'h0011]); end
        start_read(24'h000010);
        checks++; if (oe !== 1'b0) begin failures++; $display("FAIL rd_oe_dummy: got %b want 0", oe); end
        for (int i = 0; i < 4; i++) begin
            rd(n, o);
            checks++; if (n !== exp[i]) begin failures++; $display("FAIL rd_nib%0d: got %h want %h", i, n, exp[i]); end
            checks++; if (o !== 1'b1) begin failures++; $display("FAIL rd_oe%0d: got %b want 1", i, o); end
        end
        cs_hi();
        checks++; if (oe !== 1'b0) begin failures++; $display("FAIL rd_oe_cs_high: got %b want 0", oe); end
    endtask

    task automatic test_wrap();
        logic [3:0] exp [4] = '{4'h1, 4'h1, 4'h2, 4'h2};
        logic [3:0] n;
        logic       o;
        send_hdr(8'h02, 24'h00FFFF);
        for (int i = 0; i < 4; i++) nib(exp[i]);
        cs_hi();
        checks++; if (dut.u_ram.mem[16'hFFFF] !== 8'h11) begin failures++; $display("FAIL wrap_wr_ffff: got %h want 11", dut.u_ram.mem[16'hFFFF]); end
        checks++; if (dut.u_ram.mem[16'h0000] !== 8'h22) begin failures++; $display("FAIL wrap_wr_0000: got %h want 22", dut.u_ram.mem[16'h0000]); end
        start_read(24'h00FFFF);
        for (int i = 0; i < 4; i++) begin
            rd(n, o);
            checks++; if (n !== exp[i]) begin failures++; $display("FAIL wrap_rd%0d: got %h want %h", i, n, exp[i]); end
        end
        cs_hi();
    endtask

    task automatic test_bad_opcode();
        logic [3:0] tail [10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h9, 4'h9, 4'h8, 4'h8};
        logic [3:0] n;
        logic       o;
        cs_lo();
        nib(4'hF); nib(4'hF);
        for (int i = 0; i < 10; i++) begin
            nib(tail[i]);
            checks++; if (oe !== 1'b0) begin failures++; $display("FAIL bad_op_oe%0d: got %b want 0", i, oe); end
        end
        cs_hi();
        checks++; if (dut.u_ram.mem[16'h0010] !== 8'hA5) begin failures++; $display("FAIL bad_op_mem10: got %h want a5", dut.u_ram.mem[16'h0010]); end
        checks++; if (dut.u_ram.mem[16'h0011] !== 8'h3C) begin failures++; $display("FAIL bad_op_mem11: got %h want 3c", dut.u_ram.mem[16'h0011]); end
        start_read(24'h000010);
        rd(n, o);
        checks++; if (n !== 4'hA) begin failures++; $display("FAIL bad_op_next_rd: got %h want a", n); end
        cs_hi();
    endtask

    task automatic test_abort_write();
        logic [3:0] n;
        logic       o;
        dut.u_ram.mem[16'h0020] = 8'h77;
        send_hdr(8'h02, 24'h000020);
        nib(4'hE);
        cs_hi();
        checks++; if (dut.u_ram.mem[16'h0020] !== 8'h77) begin failures++; $display("FAIL abort_mem20: got %h want 77", dut.u_ram.mem[16'h0020]); end
        start_read(24'h000020);
        rd(n, o);
        checks++; if (n !== 4'h7) begin failures++; $display("FAIL abort_rd_hi: got %h want 7", n); end
        rd(n, o);
        checks++; if (n !== 4'h7) begin failures++; $display("FAIL abort_rd_lo: got %h want 7", n); end
        cs_hi();
    endtask

    task automatic test_high_addr();
        logic [3:0] n;
        logic       o;
        dut.u_ram.mem[16'h0040] = 8'h5E;
        start_read(24'hAB0040);
        rd(n, o);
        checks++; if (n !== 4'h5) begin failures++; $display("FAIL hiaddr_rd_hi: got %h want 5", n); end
        rd(n, o);
        checks++; if (n !== 4'hE) begin failures++; $display("FAIL hiaddr_rd_lo: got %h want e", n); end
        cs_hi();
    endtask

    task automatic test_reset_mid();
        logic [3:0] n;
        logic       o;
        start_read(24'h000010);
        rd(n, o);
        checks++; if (n !== 4'hA || o !== 1'b1) begin failures++; $display("FAIL mid_rd: got %h/%b want a/1", n, o); end
        rst = 1'b1; tick(1); rst = 1'b0; tick(1);
        checks++; if (sio_out !== 4'h0) begin failures++; $display("FAIL mid_rst_sio: got %h want 0", sio_out); end
        checks++; if (oe !== 1'b0) begin failures++; $display("FAIL mid_rst_oe: got %b want 0", oe); end
        checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL mid_rst_state: got %0d want %0d", dut.state, IDLE); end
        cs_hi();
    endtask

    initial begin
        tick(1);
        test_reset();
        test_write_read();
        test_wrap();
        test_bad_opcode();
        test_abort_write();
        test_high_addr();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
